// File: rtl/reg_read_pkg.sv
// Shared register-file constants for the decode, read and writeback stages.
package reg_read_pkg;

  localparam int DEF_DW   = 32;
  localparam int DEF_NREG = 32;
  localparam int DEF_AW   = 5;

  // Architectural register that is hardwired to zero.
  localparam int ZERO_REG = 0;

  // True when an address names a real, writable/claimable register.
  function automatic logic is_live_addr(input logic [31:0] addr);
    return addr != 32'(ZERO_REG);
  endfunction

endpackage

// File: rtl/regfile_core.sv
// Storage array with one write port and two asynchronous read ports;
// the zero register always reads as zero and ignores writes.
module regfile_core
  import reg_read_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_rdata,
  output logic [DW-1:0] rt_rdata
);

  logic [DW-1:0] regs [NREG];
  logic          wr_live;

  assign wr_live = we && is_live_addr(32'(wr_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // The read mux, not the array contents, is what guarantees register 0 is zero.
  assign rs_rdata = is_live_addr(32'(rs_addr)) ? regs[rs_addr] : '0;
  assign rt_rdata = is_live_addr(32'(rt_addr)) ? regs[rt_addr] : '0;

endmodule

// File: rtl/reg_read.sv
// Register-read stage: operand fetch with writeback bypass, a pending-write
// scoreboard that raises hazard, and a stallable operand output register.
module reg_read
  import reg_read_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic          stall,
  input  logic          claim,
  input  logic [AW-1:0] claim_addr,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] write_data,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic          rd_valid,
  output logic          hazard
);

  logic [DW-1:0]   rs_rdata;
  logic [DW-1:0]   rt_rdata;
  logic [DW-1:0]   rs_next;
  logic [DW-1:0]   rt_next;
  logic [NREG-1:0] pending;
  logic            wr_live;
  logic            claim_live;
  logic            rs_live;
  logic            rt_live;
  logic            rs_wr_hit;
  logic            rt_wr_hit;
  logic            rs_blocked;
  logic            rt_blocked;

  regfile_core #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (write_data),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_rdata (rs_rdata),
    .rt_rdata (rt_rdata)
  );

  assign wr_live    = we && is_live_addr(32'(wr_addr));
  assign claim_live = claim && is_live_addr(32'(claim_addr));
  assign rs_live    = is_live_addr(32'(rs_addr));
  assign rt_live    = is_live_addr(32'(rt_addr));
  assign rs_wr_hit  = wr_live && rs_live && (wr_addr == rs_addr);
  assign rt_wr_hit  = wr_live && rt_live && (wr_addr == rt_addr);

  // A pending bit being retired by this cycle's write no longer blocks the read.
  assign rs_blocked = rs_live && pending[rs_addr] && !rs_wr_hit;
  assign rt_blocked = rt_live && pending[rt_addr] && !rt_wr_hit;
  assign hazard     = rd_req && (rs_blocked || rt_blocked);

  assign rs_next = rs_wr_hit ? write_data : rs_rdata;
  assign rt_next = rt_wr_hit ? write_data : rt_rdata;

  // Clear first, then set, so a same-cycle claim wins over the retiring write.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (claim_live && (claim_addr == AW'(i))) begin
          pending[i] <= 1'b1;
        end else if (wr_live && (wr_addr == AW'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_data  <= '0;
      rt_data  <= '0;
      rd_valid <= 1'b0;
    end else if (!stall) begin
      if (rd_req && !hazard) begin
        rs_data  <= rs_next;
        rt_data  <= rt_next;
        rd_valid <= 1'b1;
      end else begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule
